// File: rtl/bcd_xs3_codec_if.sv
// Handshake bundle for bcd_xs3_codec.
//   master : the producer/consumer side (drives in_valid, in_data, mode, out_ready)
//   slave  : the codec (drives in_ready, out_valid, out_data, err_mask, out_err)
// in_data/out_data pack digit i at [4i+3:4i], digit 0 least significant.
interface bcd_xs3_codec_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;
    logic                  mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     err_mask;
    logic                  out_err;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, err_mask, out_err
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, err_mask, out_err
    );
endinterface

// File: rtl/bcd_xs3_codec.sv
// Serial multi-digit BCD <-> Excess-3 converter.
// One shared 4-bit add/sub stage converts one digit per clock; a word of
// DIGITS nibbles takes DIGITS cycles, then the result is held until taken.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : slave side of bcd_xs3_codec_if
//          in_valid/in_ready/in_data/mode   - input word handshake
//          out_valid/out_ready/out_data     - result handshake
//          err_mask (per-digit invalid), out_err (OR of err_mask)
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// CONV  | converting digit idx, one per cycle
// DONE  | result presented, held until out_ready
module bcd_xs3_codec #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    bcd_xs3_codec_if.slave    bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   word;
    logic                  mode_q;
    logic [4*DIGITS-1:0]   data_q;
    logic [DIGITS-1:0]     mask_q;
    logic                  valid_q;

    logic [3:0]            digit;
    logic [3:0]            conv;
    logic                  bad;

    // Single shared add/sub: +3 for BCD->XS3, -3 (i.e. +13 mod 16) for XS3->BCD.
    always_comb begin
        digit = word[4*idx +: 4];
        conv  = 4'hF;
        bad   = 1'b0;
        if (!mode_q) begin
            bad = (digit > 4'd9);
            if (!bad) conv = digit + 4'd3;
        end else begin
            bad = (digit < 4'd3) || (digit > 4'd12);
            if (!bad) conv = digit - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            idx     <= '0;
            word    <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word   <= bus.in_data;
                        mode_q <= bus.mode;
                        data_q <= '0;
                        mask_q <= '0;
                        idx    <= '0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    data_q[4*idx +: 4] <= conv;
                    mask_q[idx]        <= bad;
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && rstn;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.err_mask  = mask_q;
    assign bus.out_err   = |mask_q;
endmodule

// File: tb/tb_bcd_xs3_codec.sv
module tb_bcd_xs3_codec;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        int          acc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];
    logic prev_valid;
    int   acc_a;
    int   acc_b;

    bcd_xs3_codec_if #(.DIGITS(DIGITS)) bus ();

    bcd_xs3_codec #(.DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: latency check on out_valid rise, scoreboard pop on handshake.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rstn && bus.out_valid && !prev_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("latency", cyc - sb[0].acc, DIGITS);
        end
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("err_mask", bus.err_mask, e.mask);
                chk("out_err", bus.out_err, |e.mask);
            end
        end
        prev_valid <= bus.out_valid;
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input logic [15:0] d, input logic m,
                        input logic [15:0] ed, input logic [3:0] em, output int acc);
        int n;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 1, 0);
        acc = cyc + 1;
        e.data = ed;
        e.mask = em;
        e.acc  = acc;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int a;
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_err_mask", bus.err_mask, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // 1: basic BCD->XS3, in_ready low while busy
        send(16'h1234, 1'b0, 16'h4567, 4'b0000, a);
        begin
            int busy;
            busy = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.in_ready) busy++;
            end
            chk("in_ready_busy", busy, 0);
        end
        drain();

        // 2: XS3->BCD and nibble sweep in both modes
        send(16'h4567, 1'b1, 16'h1234, 4'b0000, a); drain();
        send(16'h3210, 1'b0, 16'h6543, 4'b0000, a); drain();
        send(16'h7654, 1'b0, 16'hA987, 4'b0000, a); drain();
        send(16'hBA98, 1'b0, 16'hFFCB, 4'b1100, a); drain();
        send(16'hFEDC, 1'b0, 16'hFFFF, 4'b1111, a); drain();
        send(16'h3210, 1'b1, 16'h0FFF, 4'b0111, a); drain();
        send(16'h7654, 1'b1, 16'h4321, 4'b0000, a); drain();
        send(16'hBA98, 1'b1, 16'h8765, 4'b0000, a); drain();
        send(16'hFEDC, 1'b1, 16'hFFF9, 4'b1110, a); drain();

        // 3: mixed invalid digits
        send(16'h9A05, 1'b0, 16'hCF38, 4'b0100, a); drain();
        send(16'h3C2F, 1'b1, 16'h09FF, 4'b0011, a); drain();

        // 4: back-pressure in DONE with input noise
        bus.out_ready = 1'b0;
        send(16'h1234, 1'b0, 16'h4567, 4'b0000, a);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.out_valid && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("bp_reach_done", bus.out_valid, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = 16'h0F0F ^ 16'(i * 16'h1111);
            bus.mode     = ~bus.mode;
            @(negedge clk);
            chk("bp_out_data", bus.out_data, 16'h4567);
            chk("bp_err_mask", bus.err_mask, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_queue", sb.size(), 0);
        @(posedge clk); #1;

        // 5: reset mid-CONV at idx=2 discards the word
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        bus.mode     = 1'b0;
        @(negedge clk);
        chk("r5_accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("r5_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("r5_out_valid", bus.out_valid, 0);
        chk("r5_out_data", bus.out_data, 0);
        chk("r5_err_mask", bus.err_mask, 0);
        chk("r5_out_err", bus.out_err, 0);
        chk("r5_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        send(16'h0000, 1'b0, 16'h3333, 4'b0000, a); drain();

        // 6: back-to-back words, 6 cycles apart
        @(posedge clk); #1;
        send(16'h0909, 1'b0, 16'h3C3C, 4'b0000, acc_a);
        send(16'h3C3C, 1'b1, 16'h0909, 4'b0000, acc_b);
        chk("b2b_spacing", acc_b - acc_a, 6);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_xs3_codec.md
Name: bcd_xs3_codec

Overview:
- Multi-digit, bidirectional code converter: packed 8421 BCD to Excess-3, or Excess-3 to 8421 BCD, selected per transaction.
- Handles DIGITS nibbles with one shared 4-bit add/sub datapath, serialised at one digit per clock.
- Flags invalid input digits per nibble.
- Sits between a BCD producer (counter or keypad front end) and a downstream display or arithmetic stage, with valid/ready handshakes on both sides.

Parameters:
- DIGITS, 4, number of 4-bit digits per word; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  reset
- in_valid  input  1  in_data/mode valid
- in_ready  output  1  block can accept a word
- in_data  input  4*DIGITS  packed digits; digit i = in_data[4i+3:4i], digit 0 least significant
- mode  input  1  0: BCD->XS3, 1: XS3->BCD; sampled with in_data
- out_valid  output  1  out_data/out_err/err_mask valid
- out_ready  input  1  downstream accepts result
- out_data  output  4*DIGITS  converted digits, same packing as in_data
- err_mask  output  DIGITS  bit i set = input digit i invalid
- out_err  output  1  OR of err_mask

Behaviour:
- Reset: rstn is synchronous, active-low. At a rising edge with rstn=0:
  - state goes to IDLE;
  - out_valid=0, out_data=0, err_mask=0, out_err=0, digit index=0, latched word and mode cleared.
  - rstn has priority over every other input, including mid-CONV and mid-DONE; any word in flight is discarded.
  - in_ready = (state==IDLE) && rstn, so in_ready is 0 while rstn is low.
- FSM states IDLE, CONV, DONE:
  - IDLE: in_ready=1. On an edge with in_valid=1, latch in_data and mode, clear the result and error registers, set idx=0, go to CONV.
  - CONV: in_ready=0, out_valid=0. Each cycle convert digit idx and write it to out_data[4idx+3:4idx] and err_mask[idx]. If idx==DIGITS-1, go to DONE; else idx+1.
  - DONE: out_valid=1. out_data, err_mask and out_err are held stable while out_ready=0 (unbounded back-pressure). On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: if the accept edge is t, out_valid rises after edge t+DIGITS.
  - Minimum period per word is DIGITS+2 cycles: DIGITS CONV cycles, at least 1 DONE cycle, 1 IDLE cycle.
  - No same-cycle accept-while-output in this generation.
- Conversion rules (4-bit, modulo 16, no carry between digits):
  - mode 0: valid if d<=9; result d+3 (0..9 -> 3..C).
  - mode 1: valid if 3<=d<=12; result d-3.
  - Invalid digit: result nibble forced to 4'hF and err_mask bit set; the other digits still convert normally.
- out_err is combinational from err_mask (|err_mask) and is only meaningful while out_valid=1.
- Changes on in_data, mode or in_valid outside the IDLE accept edge are ignored.
- DIGITS=1: a single CONV cycle, so out_valid rises after edge t+1.

Test Plan (DIGITS=4):
1. Reset, then in_data=16'h1234, mode=0, accepted at edge t -> out_valid after edge t+4; out_data=16'h4567, err_mask=4'b0000, out_err=0; in_ready=0 from t+1 until the handshake completes.
2. in_data=16'h4567, mode=1 -> out_data=16'h1234, out_err=0. Also sweep every nibble 0..F in both modes -> each result and err bit matches the conversion rules.
3. in_data=16'h9A05, mode=0 -> out_data=16'hCF38, err_mask=4'b0100, out_err=1. Then in_data=16'h3C2F, mode=1 -> out_data=16'h09FF, err_mask=4'b0011.
4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, in_data and mode -> outputs stable, in_ready=0, no new word accepted. Raise out_ready -> out_valid falls next edge and in_ready=1.
5. Assert rstn=0 for 1 cycle while idx=2 in CONV -> after that edge all outputs are 0 and state is IDLE. The next word 16'h0000, mode=0 -> out_data=16'h3333.
6. Back-to-back words 16'h0909 (mode 0) then 16'h3C3C (mode 1), with out_ready tied 1 -> results 16'h3C3C then 16'h0909, each 4 cycles after its accept, 6 cycles apart.
